// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory load/store paths.
package mips_mem_pkg;

    // Same encoding drives the load-extension select on the load side.
    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } st_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } buf_state_e;

    localparam logic [4:0] EXC_ADES = 5'd5;

endpackage

// File: rtl/mem_store_unit_if.sv
// Pipeline-side store/load request signals plus the data-memory write port.
interface mem_store_unit_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    st_op_e            st_op;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [31:0]       st_pc;
    logic              flush;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              dm_ack;

    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [3:0]        dm_be;
    logic              stall;
    logic              exc_ades;
    logic [31:0]       exc_badvaddr;
    logic [31:0]       exc_pc;

    // Pipeline + memory side.
    modport master (
        output st_valid, st_op, st_addr, st_data, st_pc, flush,
               ld_valid, ld_addr, dm_ack,
        input  dm_req, dm_addr, dm_wdata, dm_be, stall,
               exc_ades, exc_badvaddr, exc_pc
    );

    // Store unit side.
    modport slave (
        input  st_valid, st_op, st_addr, st_data, st_pc, flush,
               ld_valid, ld_addr, dm_ack,
        output dm_req, dm_addr, dm_wdata, dm_be, stall,
               exc_ades, exc_badvaddr, exc_pc
    );
endinterface

// File: rtl/mem_store_unit_store_align.sv
// Little-endian lane steering for SB/SH/SW: byte enables, replicated data, misalignment.
module store_align
    import mips_mem_pkg::*;
(
    input  st_op_e      i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0;
        o_misaligned = 1'b0;
        case (i_op)
            ST_SB: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_data[7:0]}};
            end
            ST_SH: begin
                o_misaligned = i_addr_lo[0];
                o_be         = i_addr_lo[0] ? 4'b0000 :
                               (i_addr_lo[1] ? 4'b1100 : 4'b0011);
                o_wdata      = {2{i_data[15:0]}};
            end
            ST_SW: begin
                o_misaligned = |i_addr_lo;
                o_be         = (|i_addr_lo) ? 4'b0000 : 4'b1111;
                o_wdata      = i_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_store_unit.sv
// One-entry store buffer between EX and data memory, with AdES detection and hazard stall.
module mem_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic           i_clk,
    input  logic           i_rst,
    mem_store_unit_if.slave bus
);

    buf_state_e        r_state;
    logic              r_dm_req;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              r_exc_ades;
    logic [31:0]       r_badvaddr;
    logic [31:0]       r_exc_pc;

    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misaligned;
    logic              w_st_live;
    logic              w_st_ok;
    logic              w_accept;
    logic              w_pend_busy;
    logic              w_ld_hit;

    store_align u_align (
        .i_op        (bus.st_op),
        .i_addr_lo   (bus.st_addr[1:0]),
        .i_data      (bus.st_data),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_misaligned(w_misaligned)
    );

    // A flushed store is invisible: no capture, no stall, no AdES.
    assign w_st_live   = bus.st_valid & (bus.st_op != ST_NONE) & ~bus.flush;
    assign w_st_ok     = w_st_live & ~w_misaligned;
    assign w_pend_busy = (r_state == PEND) & ~bus.dm_ack;
    assign w_accept    = w_st_ok & ((r_state == IDLE) | bus.dm_ack);
    assign w_ld_hit    = bus.ld_valid & w_pend_busy &
                         (bus.ld_addr[ADDR_W-1:2] == r_addr[ADDR_W-1:2]);

    assign bus.stall   = (w_st_ok & w_pend_busy) | w_ld_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_dm_req <= 1'b0;
            r_addr   <= '0;
            r_be     <= 4'b0000;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= PEND;
                        r_dm_req <= 1'b1;
                        r_addr   <= {bus.st_addr[ADDR_W-1:2], 2'b00};
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                    end
                end
                PEND: begin
                    // Ack plus a new store reloads in place so writes stream without a bubble.
                    if (bus.dm_ack) begin
                        if (w_accept) begin
                            r_addr  <= {bus.st_addr[ADDR_W-1:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                        end else begin
                            r_state  <= IDLE;
                            r_dm_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_dm_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exc_ades <= 1'b0;
            r_badvaddr <= 32'h0;
            r_exc_pc   <= 32'h0;
        end else begin
            r_exc_ades <= w_st_live & w_misaligned;
            if (w_st_live & w_misaligned) begin
                r_badvaddr <= 32'(bus.st_addr);
                r_exc_pc   <= bus.st_pc;
            end
        end
    end

    assign bus.dm_req       = r_dm_req;
    assign bus.dm_addr      = r_addr;
    assign bus.dm_be        = r_be;
    assign bus.dm_wdata     = 32'(r_wdata);
    assign bus.exc_ades     = r_exc_ades;
    assign bus.exc_badvaddr = r_badvaddr;
    assign bus.exc_pc       = r_exc_pc;

endmodule

// File: tb/tb_mem_store_unit.sv
// Scenario bench for mem_store_unit; completed memory writes are checked against a queue.
module tb_mem_store_unit;
    import mips_mem_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    wr_t  sb_q[$];

    mem_store_unit_if #(.ADDR_W(32)) bus ();

    mem_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // A write completes whenever the request is sampled together with ack.
    always @(negedge clk) begin
        if (!rst && bus.dm_req === 1'b1 && bus.dm_ack === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write got addr=%h be=%b wdata=%h required none",
                         bus.dm_addr, bus.dm_be, bus.dm_wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                if ({bus.dm_addr, bus.dm_be, bus.dm_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL sb_write got addr=%h be=%b wdata=%h required addr=%h be=%b wdata=%h",
                             bus.dm_addr, bus.dm_be, bus.dm_wdata, e.addr, e.be, e.wdata);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input st_op_e op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] pc, input logic fl);
        bus.st_valid = 1'b1;
        bus.st_op    = op;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_pc    = pc;
        bus.flush    = fl;
    endtask

    task automatic idle_st();
        bus.st_valid = 1'b0;
        bus.st_op    = ST_NONE;
        bus.st_addr  = 32'h0;
        bus.st_data  = 32'h0;
        bus.flush    = 1'b0;
    endtask

    task automatic test_reset();
        idle_st();
        bus.st_pc = 32'h0; bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.dm_ack = 1'b0;
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        vectors++;
        if ({bus.dm_req, bus.dm_be, bus.dm_addr, bus.dm_wdata} !== 69'h0) begin
            miscompares++;
            $display("FAIL reset_dm got req=%b be=%b addr=%h wdata=%h required all zero",
                     bus.dm_req, bus.dm_be, bus.dm_addr, bus.dm_wdata);
        end
        vectors++;
        if ({bus.exc_ades, bus.exc_badvaddr, bus.exc_pc, bus.stall} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_exc got ades=%b badva=%h pc=%h stall=%b required all zero",
                     bus.exc_ades, bus.exc_badvaddr, bus.exc_pc, bus.stall);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_sb();
        bus.dm_ack = 1'b1;
        drive_st(ST_SB, 32'h1003, 32'hAABBCCDD, 32'h0040_0000, 1'b0);
        sb_q.push_back('{32'h1000, 4'b1000, 32'hDDDDDDDD});
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++; $display("FAIL sb_stall got %b required 0", bus.stall);
        end
        next_cycle();
        idle_st();
        @(negedge clk);
        vectors++;
        if ({bus.dm_req, bus.dm_addr, bus.dm_be, bus.dm_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hDDDDDDDD}) begin
            miscompares++;
            $display("FAIL sb_fields got req=%b addr=%h be=%b wdata=%h required 1 00001000 1000 dddddddd",
                     bus.dm_req, bus.dm_addr, bus.dm_be, bus.dm_wdata);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.dm_req !== 1'b0) begin
            miscompares++; $display("FAIL sb_idle_after_ack got req=%b required 0", bus.dm_req);
        end
        bus.dm_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_sh_delayed();
        bus.dm_ack = 1'b0;
        drive_st(ST_SH, 32'h2002, 32'h1234ABCD, 32'h0040_0020, 1'b0);
        sb_q.push_back('{32'h2000, 4'b1100, 32'hABCDABCD});
        @(negedge clk);
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            drive_st(ST_SW, 32'h2008, 32'h55667788, 32'h0040_0024, 1'b0);
            bus.dm_ack = (c == 4);
            if (c == 4) sb_q.push_back('{32'h2008, 4'b1111, 32'h55667788});
            @(negedge clk);
            vectors++;
            if ({bus.dm_req, bus.dm_addr, bus.dm_be, bus.dm_wdata} !== {1'b1, 32'h2000, 4'b1100, 32'hABCDABCD}) begin
                miscompares++;
                $display("FAIL sh_hold_c%0d got req=%b addr=%h be=%b wdata=%h required 1 00002000 1100 abcdabcd",
                         c, bus.dm_req, bus.dm_addr, bus.dm_be, bus.dm_wdata);
            end
            vectors++;
            if (bus.stall !== (c < 4)) begin
                miscompares++; $display("FAIL sh_stall_c%0d got %b required %b", c, bus.stall, (c < 4));
            end
            next_cycle();
        end
        idle_st();
        @(negedge clk);
        vectors++;
        if ({bus.dm_req, bus.dm_addr, bus.dm_be} !== {1'b1, 32'h2008, 4'b1111}) begin
            miscompares++;
            $display("FAIL sh_no_bubble got req=%b addr=%h be=%b required 1 00002008 1111",
                     bus.dm_req, bus.dm_addr, bus.dm_be);
        end
        next_cycle();
        bus.dm_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.dm_req !== 1'b0) begin
            miscompares++; $display("FAIL sh_drain got req=%b required 0", bus.dm_req);
        end
        next_cycle();
    endtask

    task automatic test_ades();
        bus.dm_ack = 1'b0;
        drive_st(ST_SW, 32'h3001, 32'h0, 32'h0040_0010, 1'b0);
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++; $display("FAIL ades_stall got %b required 0", bus.stall);
        end
        next_cycle();
        idle_st();
        @(negedge clk);
        vectors++;
        if ({bus.dm_req, bus.exc_ades, bus.exc_badvaddr, bus.exc_pc} !== {1'b0, 1'b1, 32'h3001, 32'h0040_0010}) begin
            miscompares++;
            $display("FAIL ades_raise got req=%b ades=%b badva=%h pc=%h required 0 1 00003001 00400010",
                     bus.dm_req, bus.exc_ades, bus.exc_badvaddr, bus.exc_pc);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({bus.exc_ades, bus.exc_badvaddr} !== {1'b0, 32'h3001}) begin
            miscompares++;
            $display("FAIL ades_clear got ades=%b badva=%h required 0 00003001", bus.exc_ades, bus.exc_badvaddr);
        end
        next_cycle();
    endtask

    task automatic test_load_hazard();
        bus.dm_ack = 1'b0;
        drive_st(ST_SW, 32'h4000, 32'h0BADF00D, 32'h0040_0030, 1'b0);
        sb_q.push_back('{32'h4000, 4'b1111, 32'h0BADF00D});
        @(negedge clk);
        next_cycle();
        idle_st();
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h4002;
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b1) begin
            miscompares++; $display("FAIL ld_same_word got stall=%b required 1", bus.stall);
        end
        next_cycle();
        bus.ld_addr = 32'h4004;
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++; $display("FAIL ld_other_word got stall=%b required 0", bus.stall);
        end
        next_cycle();
        bus.ld_addr = 32'h4002; bus.dm_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++; $display("FAIL ld_ack_release got stall=%b required 0", bus.stall);
        end
        next_cycle();
        bus.ld_valid = 1'b0; bus.dm_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.dm_req !== 1'b0) begin
            miscompares++; $display("FAIL ld_drain got req=%b required 0", bus.dm_req);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        bus.dm_ack = 1'b0;
        drive_st(ST_SW, 32'h5000, 32'h11111111, 32'h0040_0040, 1'b1);
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++; $display("FAIL flush_stall got %b required 0", bus.stall);
        end
        next_cycle();
        drive_st(ST_SW, 32'h5001, 32'h22222222, 32'h0040_0044, 1'b1);
        @(negedge clk);
        vectors++;
        if (bus.dm_req !== 1'b0) begin
            miscompares++; $display("FAIL flush_no_capture got req=%b required 0", bus.dm_req);
        end
        next_cycle();
        idle_st();
        @(negedge clk);
        vectors++;
        if ({bus.dm_req, bus.exc_ades, bus.exc_badvaddr} !== {1'b0, 1'b0, 32'h3001}) begin
            miscompares++;
            $display("FAIL flush_no_ades got req=%b ades=%b badva=%h required 0 0 00003001",
                     bus.dm_req, bus.exc_ades, bus.exc_badvaddr);
        end
        next_cycle();
    endtask

    task automatic test_reset_pend();
        bus.dm_ack = 1'b0;
        drive_st(ST_SW, 32'h6000, 32'h66666666, 32'h0040_0050, 1'b0);
        @(negedge clk);
        next_cycle();
        idle_st();
        @(negedge clk);
        vectors++;
        if (bus.dm_req !== 1'b1) begin
            miscompares++; $display("FAIL rstp_pending got req=%b required 1", bus.dm_req);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.dm_ack = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.dm_req, bus.dm_be, bus.dm_addr, bus.exc_badvaddr} !== 69'h0) begin
            miscompares++;
            $display("FAIL rstp_cleared got req=%b be=%b addr=%h badva=%h required all zero",
                     bus.dm_req, bus.dm_be, bus.dm_addr, bus.exc_badvaddr);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.dm_req !== 1'b0) begin
            miscompares++; $display("FAIL rstp_idle_ack got req=%b required 0", bus.dm_req);
        end
        bus.dm_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        bus.dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h10 + 32'(4 * i);
            drive_st(ST_SW, a, 32'hC0DE0000 + 32'(i), 32'h0040_0060 + 32'(4 * i), 1'b0);
            sb_q.push_back('{a, 4'b1111, 32'hC0DE0000 + 32'(i)});
            @(negedge clk);
            vectors++;
            if (bus.stall !== 1'b0) begin
                miscompares++; $display("FAIL b2b_stall_%0d got %b required 0", i, bus.stall);
            end
            if (i > 0) begin
                vectors++;
                if ({bus.dm_req, bus.dm_addr} !== {1'b1, a - 32'h4}) begin
                    miscompares++;
                    $display("FAIL b2b_req_%0d got req=%b addr=%h required 1 %h", i, bus.dm_req, bus.dm_addr, a - 32'h4);
                end
            end
            next_cycle();
        end
        idle_st();
        @(negedge clk);
        vectors++;
        if ({bus.dm_req, bus.dm_addr} !== {1'b1, 32'h18}) begin
            miscompares++; $display("FAIL b2b_last got req=%b addr=%h required 1 00000018", bus.dm_req, bus.dm_addr);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.dm_req !== 1'b0) begin
            miscompares++; $display("FAIL b2b_drain got req=%b required 0", bus.dm_req);
        end
        bus.dm_ack = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_delayed();
        test_ades();
        test_load_hazard();
        test_flush();
        test_reset_pend();
        test_back_to_back();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++; $display("FAIL sb_leftover got %0d pending writes required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
